// File: rtl/tick_rate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tick_rate_ctrl
// Brief    : Run/stop tick generator whose period is reprogrammed through a
//            four-phase req/ack handshake. Changes take effect only at a
//            period boundary. Optional square-wave output: TICK_SQ_EN.
// Revision : 1.0
// ============================================================================
module tick_rate_ctrl #(
  parameter int CLK_HZ = 125_000_000,
  parameter int CNT_W  = 28
) (
  input  logic             clk_ht,
  input  logic             rst_n,
  input  logic             run,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_req,
  output logic             cfg_ack,
  output logic             cfg_err,
  output logic             tick,
`ifdef TICK_SQ_EN
  output logic             sq_out,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_per_rst = CNT_W'(CLK_HZ);
  localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_two     = CNT_W'(2);

  state_t           r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic [CNT_W-1:0] r_per, w_per_d;
  logic [CNT_W-1:0] r_pend, w_pend_d;
  logic             r_tick, w_tick_d;
  logic             r_ack, w_ack_d;
  logic             r_err, w_err_d;
  logic             w_wrap, w_accept, w_valid;

  assign w_wrap   = (r_cnt == (r_per - c_one));
  // PEND blocks new requests: only one period change may be in flight.
  assign w_accept = cfg_req && !r_ack && (r_state != PEND);
  assign w_valid  = (cfg_div >= c_two);

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = '0;
    w_tick_d  = 1'b0;
    w_per_d   = r_per;
    w_pend_d  = r_pend;
    w_ack_d   = r_ack;
    w_err_d   = r_err;

    if (r_ack && !cfg_req) begin
      w_ack_d = 1'b0;
    end

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_ack_d = 1'b1;
          w_err_d = !w_valid;
          if (w_valid) begin
            w_per_d = cfg_div;
          end
        end
        if (run) begin
          w_state_d = RUN;
        end
      end
      RUN: begin
        if (!run) begin
          w_state_d = IDLE;
        end else begin
          if (w_wrap) begin
            w_tick_d = 1'b1;
          end else begin
            w_cnt_d = r_cnt + c_one;
          end
          if (w_accept) begin
            if (w_valid) begin
              w_pend_d  = cfg_div;
              w_state_d = PEND;
            end else begin
              w_ack_d = 1'b1;
              w_err_d = 1'b1;
            end
          end
        end
      end
      PEND: begin
        // Stopping while a change is pending still completes the handshake.
        if (!run) begin
          w_state_d = IDLE;
          w_per_d   = r_pend;
          w_ack_d   = 1'b1;
          w_err_d   = 1'b0;
        end else if (w_wrap) begin
          w_tick_d  = 1'b1;
          w_per_d   = r_pend;
          w_ack_d   = 1'b1;
          w_err_d   = 1'b0;
          w_state_d = RUN;
        end else begin
          w_cnt_d = r_cnt + c_one;
        end
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_ht or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_per   <= c_per_rst;
      r_pend  <= c_per_rst;
      r_tick  <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_per   <= w_per_d;
      r_pend  <= w_pend_d;
      r_tick  <= w_tick_d;
      r_ack   <= w_ack_d;
      r_err   <= w_err_d;
    end
  end

`ifdef TICK_SQ_EN
  logic r_sq;

  // Computed from next-state values so the wave is aligned with r_cnt.
  always_ff @(posedge clk_ht or negedge rst_n) begin
    if (!rst_n) begin
      r_sq <= 1'b0;
    end else begin
      r_sq <= (w_state_d != IDLE) && (w_cnt_d < (w_per_d >> 1));
    end
  end

  assign sq_out = r_sq;
`endif

  assign cfg_ack = r_ack;
  assign cfg_err = r_err;
  assign tick    = r_tick;
  assign busy    = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tick_rate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tick_rate_ctrl
// Brief    : Directed self-checking bench for tick_rate_ctrl (CLK_HZ=12).
// Revision : 1.0
// ============================================================================
module tb_tick_rate_ctrl;

  localparam int CNT_W = 8;

  logic             clk_ht = 1'b0;
  logic             rst_n;
  logic             run;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_req;
  logic             cfg_ack;
  logic             cfg_err;
  logic             tick;
  logic             busy;
`ifdef TICK_SQ_EN
  logic             sq_out;
`endif

  int checks   = 0;
  int failures = 0;
  int n;

  always #5 clk_ht = ~clk_ht;

  tick_rate_ctrl #(
    .CLK_HZ(12),
    .CNT_W (CNT_W)
  ) dut (
    .clk_ht (clk_ht),
    .rst_n  (rst_n),
    .run    (run),
    .cfg_div(cfg_div),
    .cfg_req(cfg_req),
    .cfg_ack(cfg_ack),
    .cfg_err(cfg_err),
    .tick   (tick),
`ifdef TICK_SQ_EN
    .sq_out (sq_out),
`endif
    .busy   (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_ht);
    #1;
  endtask

  // Edges until tick is seen high; 999 on timeout so the count check fails.
  task automatic wait_tick(output int cnt);
    cnt = 999;
    for (int i = 1; i <= 64; i++) begin
      step();
      if (tick) begin
        cnt = i;
        break;
      end
    end
  endtask

  task automatic wait_ack(output int cnt);
    cnt = 999;
    for (int i = 1; i <= 64; i++) begin
      step();
      if (cfg_ack) begin
        cnt = i;
        break;
      end
    end
  endtask

  task automatic idle_cfg(input logic [CNT_W-1:0] div);
    cfg_div = div;
    cfg_req = 1'b1;
    step();
    cfg_req = 1'b0;
    step();
  endtask

  initial begin
    rst_n   = 1'b0;
    run     = 1'b1;
    cfg_req = 1'b0;
    cfg_div = '0;
    repeat (3) step();
    chk("rst_tick", tick, 0);
    chk("rst_ack", cfg_ack, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_busy", busy, 0);
`ifdef TICK_SQ_EN
    chk("rst_sq", sq_out, 0);
`endif

    run   = 1'b0;
    rst_n = 1'b1;
    step();

    // Reset period is CLK_HZ = 12.
    run = 1'b1;
    wait_tick(n);
    chk("rst_period_first", n, 13);
    chk("busy_run", busy, 1);
    run = 1'b0;
    step();
    chk("busy_stop", busy, 0);

    // Config 10 in IDLE: one-cycle ack latency.
    cfg_div = 8'd10;
    cfg_req = 1'b1;
    step();
    chk("idle_ack", cfg_ack, 1);
    chk("idle_err", cfg_err, 0);
    cfg_req = 1'b0;
    step();
    chk("idle_ack_release", cfg_ack, 0);
    run = 1'b1;
    wait_tick(n);
    chk("p10_first", n, 11);
    wait_tick(n);
    chk("p10_second", n, 10);
    step();
    chk("tick_width", tick, 0);
    run = 1'b0;
    step();

    // Period 4.
    idle_cfg(8'd4);
    run = 1'b1;
    wait_tick(n);
    chk("p4_first", n, 5);
    wait_tick(n);
    chk("p4_second", n, 4);
    wait_tick(n);
    chk("p4_third", n, 4);
    chk("p4_busy", busy, 1);
    run = 1'b0;
    step();
    chk("p4_stop_busy", busy, 0);
    chk("p4_stop_tick", tick, 0);

    // Period 8, change to 3 requested while cnt = 2.
    idle_cfg(8'd8);
    run = 1'b1;
    wait_tick(n);
    chk("p8_first", n, 9);
    step();
    step();
    cfg_div = 8'd3;
    cfg_req = 1'b1;
    wait_ack(n);
    chk("p8to3_ack_lat", n, 6);
    chk("p8to3_wrap_tick", tick, 1);
    chk("p8to3_err", cfg_err, 0);
    cfg_req = 1'b0;
    wait_tick(n);
    chk("p3_first", n, 3);
    chk("p3_ack_released", cfg_ack, 0);
    wait_tick(n);
    chk("p3_second", n, 3);

    // Rejected request keeps period 3.
    cfg_div = 8'd1;
    cfg_req = 1'b1;
    step();
    chk("bad_ack", cfg_ack, 1);
    chk("bad_err", cfg_err, 1);
    cfg_req = 1'b0;
    step();
    chk("bad_ack_release", cfg_ack, 0);
    wait_tick(n);
    wait_tick(n);
    chk("bad_period_kept", n, 3);

    // Valid change to 6, requested right after a tick (cnt = 0).
    cfg_div = 8'd6;
    cfg_req = 1'b1;
    wait_ack(n);
    chk("p6_ack_lat", n, 3);
    chk("p6_err_clear", cfg_err, 0);
    chk("p6_wrap_tick", tick, 1);
    cfg_req = 1'b0;
    wait_tick(n);
    chk("p6_period", n, 6);

    // Pending 7, stop while in PEND.
    cfg_div = 8'd7;
    cfg_req = 1'b1;
    step();
    chk("pend_ack_low", cfg_ack, 0);
    chk("pend_busy", busy, 1);
    run = 1'b0;
    step();
    chk("pend_stop_busy", busy, 0);
    chk("pend_stop_ack", cfg_ack, 1);
    chk("pend_stop_tick", tick, 0);
    cfg_req = 1'b0;
    step();
    chk("pend_ack_release", cfg_ack, 0);
    run = 1'b1;
    wait_tick(n);
    chk("p7_restart", n, 8);
    run = 1'b0;
    step();

`ifdef TICK_SQ_EN
    idle_cfg(8'd5);
    run = 1'b1;
    wait_tick(n);
    chk("sq_c0", sq_out, 1);
    step();
    chk("sq_c1", sq_out, 1);
    step();
    chk("sq_c2", sq_out, 0);
    step();
    chk("sq_c3", sq_out, 0);
    step();
    chk("sq_c4", sq_out, 0);
    step();
    chk("sq_wrap", sq_out, 1);
    run = 1'b0;
    step();
    chk("sq_idle", sq_out, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
